// File: rtl/jk_cmd_pkg.sv
// Shared FSM state encoding and JK command codes ({J,K}) for the JK command stage.
package jk_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_PAIR = 2'd1,
      ISSUE     = 2'd2
   } state_e;

   localparam logic [1:0] CMD_SET  = 2'b10;
   localparam logic [1:0] CMD_CLR  = 2'b01;
   localparam logic [1:0] CMD_TGL  = 2'b11;
   localparam logic [1:0] CMD_NONE = 2'b00;

endpackage

// File: rtl/jk_debounce.sv
// Button synchroniser, debouncer and rise detector; raw edge to oRise is 2+DEB_CYCLES cycles.
// No backpressure: oRise is a single-cycle pulse that downstream must take or lose.
module jk_debounce #(
   parameter int DEB_CYCLES = 16,
   parameter int CNT_W      = 8
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iBtn,
   output logic oDeb,
   output logic oRise
);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             deb_q, deb_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = iBtn;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      // Any return to the current debounced level drops the count back to zero.
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            deb_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      rise_d = deb_d & ~deb_q;
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign oDeb  = deb_q;
   assign oRise = rise_q;

endmodule

// File: rtl/jk_cmd_ctrl.sv
// Turns two raw buttons into one-cycle J/K/CE commands; oCE follows a lone rise by PAIR_WIN+1, a paired rise by 1.
// No backpressure; JK_CMD_AUTO_REPEAT_EN adds periodic reissue of a held single-channel command.
module jk_cmd_ctrl
   import jk_cmd_pkg::*;
#(
   parameter int DEB_CYCLES = 16,
   parameter int PAIR_WIN   = 4,
   parameter int CNT_W      = 8
`ifdef JK_CMD_AUTO_REPEAT_EN
   , parameter int REPEAT_CYCLES = 200
`endif
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iBtnJ,
   input  logic iBtnK,
   output logic oJ,
   output logic oK,
   output logic oCE,
   output logic oBusy
);

   logic             deb_j, deb_k, rise_j, rise_k;
   state_e           state_q, state_d;
   logic [1:0]       cmd_q, cmd_d;
   logic [1:0]       pend_q, pend_d;
   logic [CNT_W-1:0] win_q, win_d;

   jk_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_j (
      .iClk(iClk), .iRst(iRst), .iBtn(iBtnJ), .oDeb(deb_j), .oRise(rise_j)
   );

   jk_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_k (
      .iClk(iClk), .iRst(iRst), .iBtn(iBtnK), .oDeb(deb_k), .oRise(rise_k)
   );

`ifdef JK_CMD_AUTO_REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);

   logic             rpt_act;
   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

   // Only a still-held single-channel command is eligible for reissue.
   assign rpt_act = ((cmd_q == CMD_SET) && deb_j) || ((cmd_q == CMD_CLR) && deb_k);

   always_comb begin
      rpt_cnt_d = '0;
      if (state_q == ISSUE) begin
         rpt_cnt_d = RPT_W'(1);
      end else if ((state_q == IDLE) && rpt_act) begin
         rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) rpt_cnt_q <= '0;
      else      rpt_cnt_q <= rpt_cnt_d;
   end
`else
   logic unused_deb;
   assign unused_deb = deb_j ^ deb_k;
`endif

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      pend_d  = pend_q;
      win_d   = win_q;
      case (state_q)
         IDLE: begin
            if (rise_j && rise_k) begin
               state_d = ISSUE;
               cmd_d   = CMD_TGL;
            end else if (rise_j) begin
               state_d = WAIT_PAIR;
               pend_d  = CMD_SET;
               win_d   = '0;
            end else if (rise_k) begin
               state_d = WAIT_PAIR;
               pend_d  = CMD_CLR;
               win_d   = '0;
            end
`ifdef JK_CMD_AUTO_REPEAT_EN
            else if (rpt_act && (rpt_cnt_q == RPT_W'(REPEAT_CYCLES - 1))) begin
               state_d = ISSUE;
            end
`endif
         end
         WAIT_PAIR: begin
            if (((pend_q == CMD_SET) && rise_k) || ((pend_q == CMD_CLR) && rise_j)) begin
               state_d = ISSUE;
               cmd_d   = CMD_TGL;
            end else if (win_q == CNT_W'(PAIR_WIN - 1)) begin
               state_d = ISSUE;
               cmd_d   = pend_q;
            end else begin
               win_d = win_q + 1'b1;
            end
         end
         ISSUE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         cmd_q   <= CMD_NONE;
         pend_q  <= CMD_NONE;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         pend_q  <= pend_d;
         win_q   <= win_d;
      end
   end

   assign oCE   = (state_q == ISSUE);
   assign oJ    = oCE & cmd_q[1];
   assign oK    = oCE & cmd_q[0];
   assign oBusy = (state_q != IDLE);

endmodule

// File: tb/tb_jk_cmd_ctrl.sv
// Directed bench for jk_cmd_ctrl: cycle 0 is the cycle the raw edge is applied, outputs sampled mid-cycle.
module tb_jk_cmd_ctrl;

   logic iClk = 1'b0;
   logic iRst, iBtnJ, iBtnK;
   logic oJ, oK, oCE, oBusy;

   int n_chk  = 0;
   int n_pass = 0;

   int         cyc, ce_cnt, ce_first, ce_last, busy_cnt, busy_first, bad_jk;
   logic [1:0] ce_jk;
   logic [3:0] last_out;

   always #5 iClk = ~iClk;

   jk_cmd_ctrl #(.DEB_CYCLES(16), .PAIR_WIN(4), .CNT_W(8)) dut (
      .iClk(iClk), .iRst(iRst), .iBtnJ(iBtnJ), .iBtnK(iBtnK),
      .oJ(oJ), .oK(oK), .oCE(oCE), .oBusy(oBusy)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Drive one cycle of inputs, sample outputs at the falling edge, advance to just after the next rise.
   task automatic step(input logic j, input logic k, input logic r);
      iBtnJ = j;
      iBtnK = k;
      iRst  = r;
      @(negedge iClk);
      last_out = {oJ, oK, oCE, oBusy};
      if (oCE === 1'b1) begin
         if (ce_first < 0) begin
            ce_first = cyc;
            ce_jk    = {oJ, oK};
         end
         ce_last = cyc;
         ce_cnt++;
         if ({oJ, oK} === 2'b00) bad_jk++;
      end else if (oJ !== 1'b0 || oK !== 1'b0) begin
         bad_jk++;
      end
      if (oBusy === 1'b1) begin
         if (busy_first < 0) busy_first = cyc;
         busy_cnt++;
      end
      @(posedge iClk);
      #1;
      cyc++;
   endtask

   task automatic start();
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      cyc        = 0;
      ce_cnt     = 0;
      ce_first   = -1;
      ce_last    = -1;
      ce_jk      = 2'b00;
      busy_cnt   = 0;
      busy_first = -1;
      bad_jk     = 0;
   endtask

   // Buttons high on [on, off); rst_at names the single cycle with iRst high (-1 for none).
   task automatic run(input int n, input int j_on, input int j_off,
                      input int k_on, input int k_off, input int rst_at);
      for (int c = 0; c < n; c++) begin
         step(c >= j_on && c < j_off, c >= k_on && c < k_off, c == rst_at);
      end
   endtask

   initial begin
      iRst  = 1'b1;
      iBtnJ = 1'b0;
      iBtnK = 1'b0;
      @(posedge iClk);
      #1;
      cyc = 0;

      // Reset held three cycles with both buttons toggling, then one quiet cycle
      for (int c = 0; c < 3; c++) begin
         step(c[0], ~c[0], 1'b1);
         chk($sformatf("reset_hold_c%0d", c), int'(last_out), 0);
      end
      step(1'b0, 1'b0, 1'b0);
      chk("reset_release", int'(last_out), 0);

      // Glitch shorter than the debounce time
      start();
      run(40, 0, 10, 9999, 9999, -1);
      chk("glitch_ce_cnt", ce_cnt, 0);
      chk("glitch_busy_cnt", busy_cnt, 0);

      // Single J press held 60 cycles, then released (falling edge gives nothing)
      start();
      run(100, 0, 60, 9999, 9999, -1);
      chk("single_ce_cnt", ce_cnt, 1);
      chk("single_ce_cycle", ce_first, 23);
      chk("single_jk", int'(ce_jk), 2);
      chk("single_busy_first", busy_first, 19);
      chk("single_busy_cnt", busy_cnt, 5);
      chk("single_idle_jk", bad_jk, 0);

      // Single K press
      start();
      run(60, 9999, 9999, 0, 40, -1);
      chk("clear_ce_cycle", ce_first, 23);
      chk("clear_jk", int'(ce_jk), 1);

      // Paired press, K two cycles after J
      start();
      run(100, 0, 60, 2, 60, -1);
      chk("pair_ce_cnt", ce_cnt, 1);
      chk("pair_ce_cycle", ce_first, 21);
      chk("pair_jk", int'(ce_jk), 3);
      chk("pair_busy_cnt", busy_cnt, 3);

      // Simultaneous press
      start();
      run(100, 0, 60, 0, 60, -1);
      chk("simul_ce_cnt", ce_cnt, 1);
      chk("simul_ce_cycle", ce_first, 19);
      chk("simul_jk", int'(ce_jk), 3);
      chk("simul_busy_cnt", busy_cnt, 1);
      chk("simul_busy_first", busy_first, 19);

      // Partner press on the last window cycle still pairs
      start();
      run(60, 0, 40, 4, 40, -1);
      chk("win_last_ce_cnt", ce_cnt, 1);
      chk("win_last_jk", int'(ce_jk), 3);
      chk("win_last_ce_cycle", ce_first, 23);

      // Partner press one cycle later lands in ISSUE and is dropped
      start();
      run(60, 0, 40, 5, 40, -1);
      chk("win_miss_ce_cnt", ce_cnt, 1);
      chk("win_miss_jk", int'(ce_jk), 2);

      // Reset in the middle of the pairing window
      start();
      run(60, 9999, 9999, 0, 21, 20);
      chk("rst_mid_ce_cnt", ce_cnt, 0);
      chk("rst_mid_busy_cnt", busy_cnt, 2);

      // Bounce back low for two cycles restarts the debounce count
      start();
      for (int c = 0; c < 70; c++) begin
         step(!(c == 10 || c == 11), 1'b0, 1'b0);
      end
      chk("bounce_ce_cnt", ce_cnt, 1);
      chk("bounce_ce_cycle", ce_first, 35);

      // Button still held through a reset counts as a fresh press
      start();
      run(100, 0, 100, 9999, 9999, 30);
      chk("held_rst_ce_cnt", ce_cnt, 2);
      chk("held_rst_ce_last", ce_last, 54);

`ifdef JK_CMD_AUTO_REPEAT_EN
      // Held single-channel command reissues every 200 cycles
      start();
      run(520, 0, 500, 9999, 9999, -1);
      chk("repeat_ce_cnt", ce_cnt, 3);
      chk("repeat_ce_first", ce_first, 23);
      chk("repeat_ce_last", ce_last, 423);
      chk("repeat_jk", int'(ce_jk), 2);
`endif

      chk("jk_zero_without_ce", bad_jk, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/jk_cmd_ctrl.md
Name: jk_cmd_ctrl

Overview:
Upstream command stage for the team's JK register cell. Converts two raw, asynchronous push-button inputs into clean single-cycle J/K/clock-enable commands.
- Synchronises and debounces each button.
- Pairs near-coincident presses into a toggle command (J=K=1).
- Drives the JK cell's J, K and CE inputs directly.

Parameters:
DEB_CYCLES, 16, consecutive stable cycles required before a debounced level changes; range 2..2^CNT_W-1
PAIR_WIN, 4, cycles to wait after the first press for the partner press; range 1..DEB_CYCLES-1
CNT_W, 8, width of the debounce and window counters

Ports:
iClk  input  1  clock; all logic on rising edge
iRst  input  1  synchronous, active-high reset
iBtnJ  input  1  raw asynchronous "set" button
iBtnK  input  1  raw asynchronous "clear" button
oJ  output  1  J command to the JK cell; valid only while oCE=1, else 0
oK  output  1  K command to the JK cell; valid only while oCE=1, else 0
oCE  output  1  one-cycle command strobe to the JK cell's CE
oBusy  output  1  high while a command is pending or issuing

Behaviour:
- Reset (iRst=1 at a clock edge):
  - clears sync flops, debounce levels, counters, pending command and FSM (IDLE);
  - oJ=oK=oCE=oBusy=0 from the next cycle;
  - reset mid-operation drops any pending command; no oCE is produced for it;
  - a button still held after reset is treated as a new press and generates a command after the normal latency.
- Synchroniser: two flops per button, reset to 0.
- Debounce (per channel):
  - if sync == deb, cnt <= 0;
  - else cnt increments; when cnt == DEB_CYCLES-1, deb <= sync and cnt <= 0;
  - any bounce back to the deb level before the count completes restarts the count.
- Rise pulse: one cycle, asserted in the cycle deb goes 0->1. Falling edges produce no command.
- Raw-to-rise latency: 2 + DEB_CYCLES cycles.
- FSM states: IDLE, WAIT_PAIR, ISSUE.
  - IDLE:
    - both rises in the same cycle -> ISSUE, cmd=11;
    - riseJ only -> WAIT_PAIR, pend=10, win=0;
    - riseK only -> WAIT_PAIR, pend=01, win=0.
  - WAIT_PAIR:
    - rise on the other channel -> ISSUE, cmd=11;
    - else if win == PAIR_WIN-1 -> ISSUE, cmd=pend;
    - else win++.
    - A repeat rise on the same channel cannot occur here (PAIR_WIN < DEB_CYCLES).
  - ISSUE: lasts one cycle. oCE=1, {oJ,oK}=cmd; next state IDLE. Rises arriving while in ISSUE are dropped.
- Outputs are registered (Moore, decoded from state/cmd registers). oBusy=1 in WAIT_PAIR and ISSUE.
- oCE timing:
  - single press: exactly PAIR_WIN+1 cycles after the rise-pulse cycle;
  - paired press: the cycle after the second rise;
  - simultaneous rises: the cycle after the rise.
- Command encoding {J,K}: 10 = set, 01 = clear, 11 = toggle. 00 is never issued with oCE=1.

Optional Feature:
JK_CMD_AUTO_REPEAT_EN
- Defined:
  - adds parameter REPEAT_CYCLES (default 200) and a repeat counter;
  - after a single-channel command issues, if that channel's deb level stays high, the same command reissues every REPEAT_CYCLES cycles through ISSUE;
  - the counter clears when deb falls or on reset;
  - toggle (11) commands never repeat.
- Undefined: exactly one command per debounced press; no repeat counter is synthesised.

Decomposition:
- Package jk_cmd_pkg:
  - FSM state encoding (IDLE, WAIT_PAIR, ISSUE);
  - command localparams CMD_SET=2'b10, CMD_CLR=2'b01, CMD_TGL=2'b11, CMD_NONE=2'b00.
- Sub-module jk_debounce: synchroniser + debounce counter + rise detect, parameterised by DEB_CYCLES/CNT_W, instantiated once per button. The top level holds the FSM and output registers.

Test Plan:
All cases use DEB_CYCLES=16 and PAIR_WIN=4; raw edges are applied at cycle 0 unless stated.
- Reset: iRst high 3 cycles with both buttons toggling -> oJ=oK=oCE=oBusy=0 throughout and one cycle after release.
- Glitch: iBtnJ high 10 cycles, then low -> no oCE, oBusy stays 0.
- Single press: iBtnJ rises at 0, held 60 cycles -> oCE=1 only at cycle 23 with oJ=1, oK=0; no further oCE (macro off).
- Paired press: iBtnJ rises at 0, iBtnK at 2 -> exactly one oCE at cycle 21 with oJ=oK=1.
- Simultaneous press: both rise at 0 -> one oCE at cycle 19, oJ=oK=1; oBusy high cycle 19 only.
- Reset mid-pair: iBtnK rises at 0, iRst pulsed at cycle 20, button released at 21 -> no oCE ever; with macro on and iBtnJ held 500 cycles -> oCE with 10 at cycle 23, 223, 423.
